exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
Exception sequencer for the multicycle MIPS datapath; sits upstream of the PC-source mux and drives its selector, EPC input and memory-handler input.
- On an exception strobe from the control unit: saves EPC = PC-4 and reads the handler byte from the vector address in memory.
- Then forces the mux to the memory-handler path (sel 3'b101) and pulses a PC write.
- Also services return-from-exception by selecting EPC (sel 3'b011).

Parameters:
- MEM_LATENCY, 2: cycles from mem_addr_valid to mem_rdata valid; legal range 1..7.
- VEC_OPCODE, 253: byte address of the invalid-opcode handler vector.
- VEC_OVF, 254: byte address of the overflow handler vector.
- VEC_DIV0, 255: byte address of the divide-by-zero handler vector.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- exc_opcode  in  1  invalid-opcode strobe, 1 cycle.
- exc_ovf  in  1  ALU overflow strobe, 1 cycle.
- exc_div0  in  1  divide-by-zero strobe, 1 cycle.
- rfe_req  in  1  return-from-exception request, 1 cycle.
- pc_in  in  32  current PC register value.
- mem_rdata  in  32  memory read data.
- mem_addr  out  32  vector address to memory.
- mem_addr_valid  out  1  memory read request.
- epc_out  out  32  EPC register; feeds the mux EPC input.
- handler_addr  out  32  zero-extended handler byte; feeds the mux memory input.
- pc_src_sel  out  3  mux selector override.
- sel_override  out  1  1 = the control unit must use pc_src_sel.
- pc_write  out  1  PC load pulse.
- busy  out  1  exception sequence in progress.
- cause_out  out  2  latched cause (see Optional Feature).

Behaviour:
- Reset, asynchronous on reset_n low: state=IDLE; epc_out=0, handler_addr=0, mem_addr=0, cause_out=0; all 1-bit outputs 0; pc_src_sel=3'b000. Asserting reset mid-sequence aborts immediately with no PC write.
- Cause codes: 2'b01 opcode, 2'b10 overflow, 2'b11 div0.
- Priority when strobes coincide: opcode > overflow > div0. Any exception strobe beats rfe_req in the same cycle.
- IDLE:
  - Any exception strobe -> SAVE; latch cause and vector address.
  - rfe_req alone -> RET.
- SAVE (1 cycle): epc_out <= pc_in - 32'd4, modulo 2^32 (pc_in=0 gives 32'hFFFFFFFC). busy=1. -> FETCH.
- FETCH: mem_addr = vector, mem_addr_valid=1.
  - 3-bit wait counter loaded with MEM_LATENCY, decremented each cycle.
  - At 0 -> LOAD.
  - FETCH lasts exactly MEM_LATENCY cycles.
- LOAD (1 cycle): handler_addr <= {24'b0, mem_rdata[7:0]}; mem_addr_valid=0. -> JUMP.
- JUMP (1 cycle): sel_override=1, pc_src_sel=3'b101, pc_write=1. -> IDLE.
- RET (1 cycle): sel_override=1, pc_src_sel=3'b011, pc_write=1; epc_out unchanged. -> IDLE.
- busy=1 in SAVE, FETCH, LOAD, JUMP and RET.
- Strobes and rfe_req arriving while busy are dropped; a nested exception is not recorded.
- Total exception latency, strobe cycle to pc_write: 3 + MEM_LATENCY cycles.
- pc_write and sel_override are 0 in every state except JUMP and RET.

Optional Feature:
- Macro: EXC_CAUSE_REG_EN.
- Defined: cause_out holds the last accepted cause until the next exception or reset. rfe_req does not clear it.
- Undefined: cause_out is tied to 2'b00 and no cause flops are inferred.
- State sequencing is identical in both builds.

Decomposition:
- Package exc_pkg holds:
  - state enum: IDLE, SAVE, FETCH, LOAD, JUMP, RET;
  - cause codes;
  - selector constants SEL_PC4=3'b000, SEL_EPC=3'b011, SEL_MEMH=3'b101;
  - default vector addresses.
- One sub-module, exc_wait_cnt: loadable down-counter with a zero flag, used for the FETCH wait.

Test Plan:
1. Reset with reset_n=0 mid-FETCH -> all outputs return to 0 immediately, state IDLE, no pc_write.
2. pc_in=32'h00000040, exc_ovf pulse, MEM_LATENCY=2, mem_rdata=32'h000000A7 -> epc_out=32'h0000003C; mem_addr=254 valid for 2 cycles; handler_addr=32'h000000A7; pc_write with sel 3'b101 exactly 5 cycles after the strobe.
3. exc_opcode, exc_ovf and exc_div0 in the same cycle -> mem_addr=253; cause_out=2'b01 when EXC_CAUSE_REG_EN is defined.
4. exc_div0 during busy (in FETCH) -> ignored; single pc_write; mem_addr stays 254 from the first exception.
5. epc_out=32'h0000003C, then rfe_req in IDLE -> next cycle pc_src_sel=3'b011, sel_override=1, pc_write=1 for 1 cycle; epc_out unchanged.
6. pc_in=0 with exc_div0 -> epc_out=32'hFFFFFFFC, mem_addr=255, mem_rdata=32'hFFFFFF12 gives handler_addr=32'h00000012.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared types and constants for the exception sequencer: FSM states,
// cause codes, PC-source selector values and default vector addresses.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SAVE  = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    JUMP  = 3'd4,
    RET   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } cause_t;

  localparam logic [2:0] SEL_PC4  = 3'b000;
  localparam logic [2:0] SEL_EPC  = 3'b011;
  localparam logic [2:0] SEL_MEMH = 3'b101;

  localparam int unsigned DEF_VEC_OPCODE = 253;
  localparam int unsigned DEF_VEC_OVF    = 254;
  localparam int unsigned DEF_VEC_DIV0   = 255;

  // Wait counter width; holds memory latencies 1..7.
  localparam int CNT_W = 3;

  // Fixed priority among coincident strobes: opcode > overflow > div0.
  function automatic cause_t pick_cause(input logic opc, input logic ovf, input logic div0);
    if (opc)       return CAUSE_OPCODE;
    else if (ovf)  return CAUSE_OVF;
    else if (div0) return CAUSE_DIV0;
    else           return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Memory read port between the exception sequencer (master) and memory (slave).
//
// Handshake: the master raises mem_addr_valid with a stable mem_addr and holds
// both for MEM_LATENCY cycles. There is no ready/backpressure: the slave must
// present mem_rdata exactly MEM_LATENCY cycles after mem_addr_valid rises,
// which is the cycle right after mem_addr_valid falls.
interface exception_ctrl_if;
  logic [31:0] mem_addr;
  logic        mem_addr_valid;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_addr_valid, input mem_rdata);
  modport slave  (input mem_addr, input mem_addr_valid, output mem_rdata);
endinterface

// File: rtl/exception_ctrl_wait_cnt.sv
// Loadable down-counter with zero flag; times the FETCH wait for memory data.
// Decrement stops at zero so a stray enable cannot wrap the count.
module exc_wait_cnt
  import exc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load has priority over decrement; hold at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/exception_ctrl.sv
// Exception sequencer for the multicycle MIPS datapath. Saves EPC = PC-4,
// fetches the handler byte from the cause's vector address, then overrides
// the PC-source mux to jump to the handler; also services return-from-exception.
// Optional build macro: EXC_CAUSE_REG_EN keeps the last accepted cause on
// cause_out; without it cause_out is constant 2'b00.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,   // legal range 1..7
  parameter int unsigned VEC_OPCODE  = DEF_VEC_OPCODE,
  parameter int unsigned VEC_OVF     = DEF_VEC_OVF,
  parameter int unsigned VEC_DIV0    = DEF_VEC_DIV0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      exc_opcode,
  input  logic                      exc_ovf,
  input  logic                      exc_div0,
  input  logic                      rfe_req,
  input  logic [31:0]               pc_in,
  exception_ctrl_if.master          mem,
  output logic [31:0]               epc_out,
  output logic [31:0]               handler_addr,
  output logic [2:0]                pc_src_sel,
  output logic                      sel_override,
  output logic                      pc_write,
  output logic                      busy,
  output logic [1:0]                cause_out,
  output state_t                    dbg_state
);

  state_t      r_state;
  logic [31:0] r_epc;
  logic [31:0] r_handler;
  logic [31:0] r_mem_addr;
  logic        r_mem_valid;
  logic [2:0]  r_sel;
  logic        r_override;
  logic        r_pc_write;
  logic        r_busy;

  cause_t      w_cause;
  logic        w_any_exc;
  logic [31:0] w_vector;
  logic        w_cnt_load;
  logic        w_cnt_dec;
  logic        w_cnt_zero;
  logic        w_unused_rdata;

  assign w_cause   = pick_cause(exc_opcode, exc_ovf, exc_div0);
  assign w_any_exc = exc_opcode | exc_ovf | exc_div0;
  // Only the low byte of the vector word is the handler address.
  assign w_unused_rdata = |mem.mem_rdata[31:8];

  // Vector address for the winning cause.
  always_comb begin
    w_vector = 32'(VEC_OPCODE);
    case (w_cause)
      CAUSE_OVF:  w_vector = 32'(VEC_OVF);
      CAUSE_DIV0: w_vector = 32'(VEC_DIV0);
      default:    w_vector = 32'(VEC_OPCODE);
    endcase
  end

  // Counter is loaded on strobe acceptance and counts down through SAVE and
  // FETCH, so it reaches zero in the last of the MEM_LATENCY FETCH cycles.
  assign w_cnt_load = (r_state == IDLE) && w_any_exc;
  assign w_cnt_dec  = (r_state == SAVE) || (r_state == FETCH);

  exc_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(MEM_LATENCY)),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Sequencer FSM; every output is a register updated on the state transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_epc       <= '0;
      r_handler   <= '0;
      r_mem_addr  <= '0;
      r_mem_valid <= 1'b0;
      r_sel       <= SEL_PC4;
      r_override  <= 1'b0;
      r_pc_write  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_exc) begin
            r_state    <= SAVE;
            r_mem_addr <= w_vector;
            r_busy     <= 1'b1;
          end else if (rfe_req) begin
            r_state    <= RET;
            r_busy     <= 1'b1;
            r_override <= 1'b1;
            r_sel      <= SEL_EPC;
            r_pc_write <= 1'b1;
          end
        end
        SAVE: begin
          r_epc       <= pc_in - 32'd4;
          r_mem_valid <= 1'b1;
          r_state     <= FETCH;
        end
        FETCH: begin
          if (w_cnt_zero) begin
            r_mem_valid <= 1'b0;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          r_handler  <= {24'b0, mem.mem_rdata[7:0]};
          r_override <= 1'b1;
          r_sel      <= SEL_MEMH;
          r_pc_write <= 1'b1;
          r_state    <= JUMP;
        end
        JUMP, RET: begin
          r_override <= 1'b0;
          r_sel      <= SEL_PC4;
          r_pc_write <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef EXC_CAUSE_REG_EN
  cause_t r_cause;

  // Remember the last accepted cause; return-from-exception leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cause <= CAUSE_NONE;
    end else if (w_cnt_load) begin
      r_cause <= w_cause;
    end
  end

  assign cause_out = r_cause;
`else
  assign cause_out = CAUSE_NONE;
`endif

  assign mem.mem_addr       = r_mem_addr;
  assign mem.mem_addr_valid = r_mem_valid;
  assign epc_out            = r_epc;
  assign handler_addr       = r_handler;
  assign pc_src_sel         = r_sel;
  assign sel_override       = r_override;
  assign pc_write           = r_pc_write;
  assign busy               = r_busy;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: memory model with fixed read latency,
// scoreboard of expected mux-override results popped on every pc_write.
module tb_exception_ctrl;
  import exc_pkg::*;

  localparam int unsigned LAT = 2;
  localparam int W = 70;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        exc_opcode, exc_ovf, exc_div0, rfe_req;
  logic [31:0] pc_in;
  logic [31:0] epc_out, handler_addr;
  logic [2:0]  pc_src_sel;
  logic        sel_override, pc_write, busy;
  logic [1:0]  cause_out;
  state_t      dbg_state;

  always #5 clk = ~clk;

  exception_ctrl_if mem_if ();

  exception_ctrl #(.MEM_LATENCY(LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .exc_opcode   (exc_opcode),
    .exc_ovf      (exc_ovf),
    .exc_div0     (exc_div0),
    .rfe_req      (rfe_req),
    .pc_in        (pc_in),
    .mem          (mem_if),
    .epc_out      (epc_out),
    .handler_addr (handler_addr),
    .pc_src_sel   (pc_src_sel),
    .sel_override (sel_override),
    .pc_write     (pc_write),
    .busy         (busy),
    .cause_out    (cause_out),
    .dbg_state    (dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int pw_count = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input logic [2:0] s, input logic ov, input logic [31:0] e,
                                      input logic [31:0] h, input logic [1:0] c);
    return {s, ov, e, h, c};
  endfunction

  function automatic logic [1:0] exp_c(input logic [1:0] c);
`ifdef EXC_CAUSE_REG_EN
    return c;
`else
    return 2'b00 & c;
`endif
  endfunction

  function automatic logic [127:0] outs_all();
    return 128'({epc_out, handler_addr, mem_if.mem_addr, mem_if.mem_addr_valid, pc_src_sel,
                 sel_override, pc_write, busy, cause_out});
  endfunction

  // ---------------- memory model ----------------
  // Returns the programmed word only in the cycle after valid was held for
  // exactly LAT cycles; anything else reads back junk with low byte 0x55.
  logic [31:0] mem_data;
  int          vrun = 0;
  always @(negedge clk) begin
    if (mem_if.mem_addr_valid === 1'b1) begin
      vrun++;
      mem_if.mem_rdata = 32'hBAD0_0055;
    end else begin
      mem_if.mem_rdata = (vrun == LAT) ? mem_data : 32'hBAD0_0055;
      vrun = 0;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (pc_write === 1'b1) begin
      pw_count++;
      if (exp_q.size() == 0) begin
        chk("pc_write_unexpected", 128'(pc_write), 128'(0));
      end else begin
        chk("jump_result", 128'(pk(pc_src_sel, sel_override, epc_out, handler_addr, cause_out)),
            128'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Steps negedges after a strobe was driven until pc_write shows up.
  // Strobes are dropped after the first cycle; inject_at>0 fires exc_div0
  // once at that step. Reports latency, valid cycles and address mismatches.
  task automatic run_seq(input logic [31:0] exp_vec, input int inject_at,
                         output int lat, output int vcnt, output int bad_addr);
    lat = 0; vcnt = 0; bad_addr = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_if.mem_addr_valid === 1'b1) begin
        vcnt++;
        if (mem_if.mem_addr !== exp_vec) bad_addr++;
      end
      exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0; rfe_req = 1'b0;
      if (pc_write === 1'b1) break;
      if (lat == inject_at) exc_div0 = 1'b1;
    end
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    chk({tag, "_idle"}, 128'({dbg_state, busy, pc_write, sel_override, pc_src_sel}),
        128'({IDLE, 1'b0, 1'b0, 1'b0, SEL_PC4}));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat, vcnt, bad, pw0;
    reset_n = 1'b0;
    exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0; rfe_req = 1'b0;
    pc_in = 32'h0; mem_data = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs_all(), 128'(0));
    chk("reset_state", 128'(dbg_state), 128'(IDLE));
    reset_n = 1'b1;
    @(negedge clk);

    // 1: async reset during FETCH aborts with no pc_write
    pc_in = 32'h80; mem_data = 32'h11; exc_opcode = 1'b1;
    @(negedge clk); exc_opcode = 1'b0;
    @(negedge clk);
    chk("t1_in_fetch", 128'({dbg_state, mem_if.mem_addr_valid}), 128'({FETCH, 1'b1}));
    pw0 = pw_count;
    reset_n = 1'b0;
    #1;
    chk("t1_async_outputs", outs_all(), 128'(0));
    chk("t1_async_state", 128'(dbg_state), 128'(IDLE));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_no_pc_write", 128'(pw_count - pw0), 128'(0));

    // 2: overflow at pc 0x40
    pc_in = 32'h40; mem_data = 32'h0000_00A7; exc_ovf = 1'b1;
    exp_q.push_back(pk(SEL_MEMH, 1'b1, 32'h3C, 32'hA7, exp_c(2'b10)));
    pw0 = pw_count;
    run_seq(32'd254, 0, lat, vcnt, bad);
    chk("t2_latency", 128'(lat), 128'(LAT + 3));
    chk("t2_valid_cycles", 128'(vcnt), 128'(LAT));
    chk("t2_vec_addr", 128'(bad), 128'(0));
    chk("t2_epc_handler", 128'({epc_out, handler_addr}), 128'({32'h3C, 32'hA7}));
    check_idle_after("t2");
    chk("t2_single_pw", 128'(pw_count - pw0), 128'(1));

    // 4: div0 arriving during FETCH is dropped
    pc_in = 32'h40; mem_data = 32'h0000_C35A; exc_ovf = 1'b1;
    exp_q.push_back(pk(SEL_MEMH, 1'b1, 32'h3C, 32'h5A, exp_c(2'b10)));
    pw0 = pw_count;
    run_seq(32'd254, 2, lat, vcnt, bad);
    chk("t4_latency", 128'(lat), 128'(LAT + 3));
    chk("t4_vec_addr", 128'({bad, mem_if.mem_addr}), 128'({32'd0, 32'd254}));
    check_idle_after("t4");
    repeat (LAT + 4) @(negedge clk);
    chk("t4_single_pw", 128'(pw_count - pw0), 128'(1));
    chk("t4_addr_kept", 128'(mem_if.mem_addr), 128'(254));

    // 5: return from exception selects EPC for one cycle
    rfe_req = 1'b1; pc_in = 32'h200;
    exp_q.push_back(pk(SEL_EPC, 1'b1, 32'h3C, 32'h5A, exp_c(2'b10)));
    @(negedge clk); rfe_req = 1'b0;
    chk("t5_ret", 128'({dbg_state, busy, pc_write, sel_override, pc_src_sel, epc_out}),
        128'({RET, 1'b1, 1'b1, 1'b1, SEL_EPC, 32'h3C}));
    check_idle_after("t5");
    chk("t5_epc_kept", 128'({epc_out, cause_out}), 128'({32'h3C, exp_c(2'b10)}));

    // 3: all strobes plus rfe together -> opcode wins
    pc_in = 32'h100; mem_data = 32'h0000_0733;
    exc_opcode = 1'b1; exc_ovf = 1'b1; exc_div0 = 1'b1; rfe_req = 1'b1;
    exp_q.push_back(pk(SEL_MEMH, 1'b1, 32'hFC, 32'h33, exp_c(2'b01)));
    run_seq(32'd253, 0, lat, vcnt, bad);
    chk("t3_latency", 128'({lat, vcnt, bad}), 128'({LAT + 3, LAT, 32'd0}));
    check_idle_after("t3");
    chk("t3_cause", 128'(cause_out), 128'(exp_c(2'b01)));

    // 6: pc 0 wraps EPC, div0 vector, upper data bits ignored
    pc_in = 32'h0; mem_data = 32'hFFFF_FF12; exc_div0 = 1'b1;
    exp_q.push_back(pk(SEL_MEMH, 1'b1, 32'hFFFF_FFFC, 32'h12, exp_c(2'b11)));
    run_seq(32'd255, 0, lat, vcnt, bad);
    chk("t6_latency", 128'({lat, vcnt, bad}), 128'({LAT + 3, LAT, 32'd0}));
    check_idle_after("t6");

    // final report
    repeat (3) @(negedge clk);
    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    chk("total_pc_writes", 128'(pw_count), 128'(5));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
